// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word request, response WAIT_CYCLES+1 edges after accept.
// Backpressure: req_ready only in IDLE; the response is held until resp_ready.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] off;
    logic [31:0] idx_full;
    logic [AW-1:0] idx;
    logic        acc_err;
    logic        mem_wr;

    // Plain 32-bit subtraction; the explicit below-base test catches the wrapped case.
    assign off      = addr_q - BASE_ADDR;
    assign idx_full = off >> 2;
    assign idx      = idx_full[AW-1:0];
    assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                      (idx_full >= 32'(DEPTH_WORDS));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                err_d   = acc_err;
                rdata_d = (acc_err || we_q) ? 32'h0 : mem_q[idx];
                mem_wr  = we_q && !acc_err;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset by design.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES 0 and 3) checked against a word-array model.
module tb_dmem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk;
    logic [1:0]  rst_n;
    logic [1:0]  req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic [31:0] resp_rdata [2];

    int errors;
    int checks;

    logic [31:0] model_mem [2][DEPTH];
    bit          model_vld [2][DEPTH];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .BASE_ADDR  (BASE),
            .WAIT_CYCLES((g == 0) ? 0 : 3)
        ) u_dut (
            .clk       (clk),
            .reset     (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    function automatic bit exp_err(input logic [31:0] a);
        longint la;
        la = longint'({32'h0, a});
        return (a[1:0] != 2'b00) || (la < longint'({32'h0, BASE})) ||
               (la >= longint'({32'h0, BASE}) + 4 * DEPTH);
    endfunction

    task automatic model_apply(input int s, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] st,
                               output logic [31:0] rd, output logic er, output bit known);
        int i;
        er    = exp_err(a);
        rd    = 32'h0;
        known = 1'b1;
        if (!er) begin
            i = int'((a - BASE) / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) model_mem[s][i][8*b +: 8] = wd[8*b +: 8];
                if (st == 4'hF) model_vld[s][i] = 1'b1;
            end else begin
                rd    = model_mem[s][i];
                known = model_vld[s][i];
            end
        end
    endtask

    // Drives one request from an idle instance and completes the response handshake.
    task automatic xact(input int s, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int lat);
        req_we[s]    = we;
        req_addr[s]  = a;
        req_wdata[s] = wd;
        req_wstrb[s] = st;
        req_valid[s] = 1'b1;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid[s] && lat < 64);
        rd = resp_rdata[s];
        er = resp_err[s];
        resp_ready[s] = 1'b1;
        @(posedge clk); #1;
        resp_ready[s] = 1'b0;
    endtask

    task automatic test_reset(input int s);
        rst_n[s] = 1'b0;
        #2;
        checks++;
        if ({req_ready[s], resp_valid[s], resp_rdata[s], resp_err[s]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset[%0d]: got rdy=%b vld=%b rdata=%h err=%b, want rdy=1 vld=0 rdata=0 err=0",
                     s, req_ready[s], resp_valid[s], resp_rdata[s], resp_err[s]);
        end
        rst_n[s] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input int s);
        logic [31:0] rd, erd;
        logic er, eer;
        bit kn;
        int lat;
        model_apply(s, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, erd, eer, kn);
        xact(s, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++;
        if ({rd, er, lat} !== {erd, eer, wait_of(s) + 1}) begin
            errors++;
            $display("FAIL basic_write[%0d]: got rdata=%h err=%b lat=%0d, want %h %b %0d", s, rd, er, lat, erd, eer, wait_of(s) + 1);
        end
        model_apply(s, 1'b0, BASE + 32'h10, 32'h0, 4'h0, erd, eer, kn);
        xact(s, 1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er, lat} !== {32'hDEADBEEF, 1'b0, wait_of(s) + 1}) begin
            errors++;
            $display("FAIL basic_read[%0d]: got rdata=%h err=%b lat=%0d, want deadbeef 0 %0d", s, rd, er, lat, wait_of(s) + 1);
        end
    endtask

    task automatic test_strobe(input int s);
        logic [31:0] rd, erd;
        logic er, eer;
        bit kn;
        int lat;
        model_apply(s, 1'b1, BASE + 32'h10, 32'h0000AA00, 4'b0010, erd, eer, kn);
        xact(s, 1'b1, BASE + 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat);
        model_apply(s, 1'b0, BASE + 32'h10, 32'h0, 4'h0, erd, eer, kn);
        xact(s, 1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {erd, eer}) begin
            errors++;
            $display("FAIL strobe_read[%0d]: got rdata=%h err=%b, want %h %b", s, rd, er, erd, eer);
        end
        model_apply(s, 1'b1, BASE + 32'h10, 32'hFFFFFFFF, 4'h0, erd, eer, kn);
        xact(s, 1'b1, BASE + 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {32'h0, 1'b0}) begin
            errors++;
            $display("FAIL nostrobe_write[%0d]: got rdata=%h err=%b, want 0 0", s, rd, er);
        end
        xact(s, 1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {32'hDEADAAEF, 1'b0}) begin
            errors++;
            $display("FAIL nostrobe_read[%0d]: got rdata=%h err=%b, want deadaaef 0", s, rd, er);
        end
    endtask

    task automatic test_misaligned(input int s);
        logic [31:0] rd, erd;
        logic er, eer;
        bit kn;
        int lat;
        model_apply(s, 1'b1, BASE + 32'h13, 32'h12345678, 4'hF, erd, eer, kn);
        xact(s, 1'b1, BASE + 32'h13, 32'h12345678, 4'hF, rd, er, lat);
        checks++;
        if ({rd, er, lat} !== {32'h0, 1'b1, wait_of(s) + 1}) begin
            errors++;
            $display("FAIL misaligned_write[%0d]: got rdata=%h err=%b lat=%0d, want 0 1 %0d", s, rd, er, lat, wait_of(s) + 1);
        end
        model_apply(s, 1'b0, BASE + 32'h10, 32'h0, 4'h0, erd, eer, kn);
        xact(s, 1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {erd, eer}) begin
            errors++;
            $display("FAIL misaligned_after[%0d]: got rdata=%h err=%b, want %h %b", s, rd, er, erd, eer);
        end
    endtask

    task automatic test_range(input int s);
        logic [31:0] rd, erd;
        logic er, eer;
        bit kn;
        int lat;
        xact(s, 1'b0, BASE + 4 * DEPTH, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL range_top[%0d]: got rdata=%h err=%b, want 0 1", s, rd, er);
        end
        xact(s, 1'b0, BASE - 4, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL range_below[%0d]: got rdata=%h err=%b, want 0 1", s, rd, er);
        end
        model_apply(s, 1'b1, BASE + 4 * (DEPTH - 1), 32'hA5A50001, 4'hF, erd, eer, kn);
        xact(s, 1'b1, BASE + 4 * (DEPTH - 1), 32'hA5A50001, 4'hF, rd, er, lat);
        xact(s, 1'b0, BASE + 4 * (DEPTH - 1), 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {32'hA5A50001, 1'b0}) begin
            errors++;
            $display("FAIL range_last[%0d]: got rdata=%h err=%b, want a5a50001 0", s, rd, er);
        end
    endtask

    task automatic test_backpressure(input int s);
        logic [31:0] rd0, rd, erd;
        logic er0, er, eer;
        bit kn;
        int lat;
        model_apply(s, 1'b0, BASE + 32'h10, 32'h0, 4'h0, erd, eer, kn);
        req_we[s] = 1'b0; req_addr[s] = BASE + 32'h10; req_wstrb[s] = 4'h0;
        req_valid[s] = 1'b1;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!resp_valid[s] && lat < 64);
        rd0 = resp_rdata[s];
        er0 = resp_err[s];
        checks++;
        if ({rd0, er0, lat} !== {erd, eer, wait_of(s) + 1}) begin
            errors++;
            $display("FAIL bp_first[%0d]: got rdata=%h err=%b lat=%0d, want %h %b %0d", s, rd0, er0, lat, erd, eer, wait_of(s) + 1);
        end
        // A competing write waits on the port while the response is stalled.
        req_we[s] = 1'b1; req_addr[s] = BASE + 32'h18; req_wdata[s] = 32'h0BADF00D; req_wstrb[s] = 4'hF;
        req_valid[s] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({resp_valid[s], resp_rdata[s], resp_err[s], req_ready[s]} !== {1'b1, erd, eer, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d] cyc%0d: got vld=%b rdata=%h err=%b rdy=%b, want 1 %h %b 0",
                         s, i, resp_valid[s], resp_rdata[s], resp_err[s], req_ready[s], erd, eer);
            end
        end
        resp_ready[s] = 1'b1;
        @(posedge clk); #1;
        resp_ready[s] = 1'b0;
        checks++;
        if ({resp_valid[s], resp_rdata[s], resp_err[s], req_ready[s]} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bp_release[%0d]: got vld=%b rdata=%h err=%b rdy=%b, want 0 0 0 1",
                     s, resp_valid[s], resp_rdata[s], resp_err[s], req_ready[s]);
        end
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        checks++;
        if (req_ready[s] !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept[%0d]: got rdy=%b, want 0", s, req_ready[s]);
        end
        model_apply(s, 1'b1, BASE + 32'h18, 32'h0BADF00D, 4'hF, erd, eer, kn);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!resp_valid[s] && lat < 64);
        checks++;
        if (lat !== wait_of(s) + 1) begin
            errors++;
            $display("FAIL bp_second_lat[%0d]: got lat=%0d, want %0d", s, lat, wait_of(s) + 1);
        end
        resp_ready[s] = 1'b1;
        @(posedge clk); #1;
        resp_ready[s] = 1'b0;
        xact(s, 1'b0, BASE + 32'h18, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {32'h0BADF00D, 1'b0}) begin
            errors++;
            $display("FAIL bp_second_data[%0d]: got rdata=%h err=%b, want 0badf00d 0", s, rd, er);
        end
    endtask

    task automatic test_random(input int s);
        logic [31:0] a, wd, rd, erd;
        logic [3:0] st;
        logic er, eer, we;
        bit kn;
        int lat, kind;
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
                1: a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 100);
                2: a = BASE - 4 * $urandom_range(1, 100);
                default: a = BASE + 4 * $urandom_range(0, 15);
            endcase
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            st = (($urandom_range(0, 1)) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            model_apply(s, we, a, wd, st, erd, eer, kn);
            xact(s, we, a, wd, st, rd, er, lat);
            if (!kn) erd = rd;
            checks++;
            if ({rd, er, lat} !== {erd, eer, wait_of(s) + 1}) begin
                errors++;
                $display("FAIL random[%0d] #%0d we=%b a=%h: got rdata=%h err=%b lat=%0d, want %h %b %0d",
                         s, n, we, a, rd, er, lat, erd, eer, wait_of(s) + 1);
            end
        end
    endtask

    task automatic test_reset_wait(input int s);
        logic [31:0] rd, erd;
        logic er, eer;
        bit kn;
        int lat;
        model_apply(s, 1'b1, BASE + 32'h20, 32'h11112222, 4'hF, erd, eer, kn);
        xact(s, 1'b1, BASE + 32'h20, 32'h11112222, 4'hF, rd, er, lat);
        req_we[s] = 1'b1; req_addr[s] = BASE + 32'h20; req_wdata[s] = 32'hCAFEF00D; req_wstrb[s] = 4'hF;
        req_valid[s] = 1'b1;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        @(posedge clk); #2;
        rst_n[s] = 1'b0;
        #1;
        checks++;
        if ({req_ready[s], resp_valid[s], resp_rdata[s], resp_err[s]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_wait_outputs[%0d]: got rdy=%b vld=%b rdata=%h err=%b, want 1 0 0 0",
                     s, req_ready[s], resp_valid[s], resp_rdata[s], resp_err[s]);
        end
        #3;
        rst_n[s] = 1'b1;
        @(posedge clk); #1;
        model_apply(s, 1'b0, BASE + 32'h20, 32'h0, 4'h0, erd, eer, kn);
        xact(s, 1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if ({rd, er} !== {erd, eer}) begin
            errors++;
            $display("FAIL reset_wait_data[%0d]: got rdata=%h err=%b, want %h %b", s, rd, er, erd, eer);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk = 1'b0;
        rst_n = 2'b00;
        req_valid = 2'b00;
        req_we = 2'b00;
        resp_ready = 2'b00;
        for (int s = 0; s < 2; s++) begin
            req_addr[s] = 32'h0;
            req_wdata[s] = 32'h0;
            req_wstrb[s] = 4'h0;
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[s][i] = 32'h0;
                model_vld[s][i] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            test_reset(s);
            test_basic(s);
            test_strobe(s);
            test_misaligned(s);
            test_range(s);
            test_backpressure(s);
            test_random(s);
        end
        test_reset_wait(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
